// File: rtl/led_regs_pkg.sv
// Register map shared by the LED controller and anything that drives its bus.
// Holds register addresses, MODE bit positions and register reset values.
package led_regs_pkg;

    typedef enum logic [1:0] {
        ADDR_PATTERN   = 2'd0,
        ADDR_MODE      = 2'd1,
        ADDR_BRIGHT    = 2'd2,
        ADDR_BLINK_DIV = 2'd3
    } reg_addr_e;

    localparam int unsigned MODE_BLINK_EN = 0;
    localparam int unsigned MODE_PWM_EN   = 1;

    localparam logic [7:0] RST_PATTERN   = 8'h00;
    localparam logic [1:0] RST_MODE      = 2'b00;  // only the two defined MODE bits are stored
    localparam logic [7:0] RST_BRIGHT    = 8'hFF;
    localparam logic [7:0] RST_BLINK_DIV = 8'h00;

endpackage

// File: rtl/led_ctrl_if.sv
// Valid/ready register bus for the LED controller.
//   valid  : transaction request        (master -> slave)
//   we     : 1 = write, 0 = read        (master -> slave)
//   addr   : register index             (master -> slave)
//   wdata  : write data                 (master -> slave)
//   ready  : slave accepts this cycle   (slave -> master)
//   rdata  : read data, valid with rvalid (slave -> master)
//   rvalid : one-cycle read data strobe (slave -> master)
interface led_ctrl_if;

    logic       valid;
    logic       ready;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rdata, rvalid
    );

endinterface

// File: rtl/led_blink_timer.sv
// Blink phase generator: a free-running prescaler produces one tick every
// 2^PRESCALE_W cycles; every (div+1) ticks the phase toggles.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   div     : ticks per half-period minus one
//   restart : clears the tick counter and forces phase high (wins over a tick)
//   phase   : 1 = LEDs may be lit
module led_blink_timer #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] div,
    input  logic       restart,
    output logic       phase
);

    logic [PRESCALE_W-1:0] prescaler;
    logic [7:0]            blink_cnt;
    logic                  tick;

    assign tick = &prescaler;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (restart) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (tick) begin
                if (blink_cnt == div) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// Memory-mapped LED controller: register file (PATTERN, MODE, BRIGHT,
// BLINK_DIV), PWM dimming and blink gating of the registered LED vector.
//   Mv2_CLK : system clock, rising edge
//   Mv2_RST : asynchronous active-high reset
//   bus     : valid/ready register bus (slave side)
//   Mv2_LED : registered LED drive, 1 = lit
module led_ctrl
    import led_regs_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic       Mv2_CLK,
    input  logic       Mv2_RST,
    led_ctrl_if.slave  bus,
    output logic [7:0] Mv2_LED
);

    logic [7:0] pattern;
    logic [1:0] mode;
    logic [7:0] bright;
    logic [7:0] blink_div;
    logic [7:0] pwm_cnt;
    logic [7:0] rd_val;
    logic [7:0] rdata;
    logic       ready;
    logic       rvalid;
    logic       accept;
    logic       restart;
    logic       pwm_on;
    logic       phase;
    logic       blink_gate;

    assign bus.ready  = ready;
    assign bus.rdata  = rdata;
    assign bus.rvalid = rvalid;

    assign accept  = bus.valid & ready;
    assign restart = accept & bus.we & (bus.addr == ADDR_BLINK_DIV);

    always_comb begin
        rd_val = '0;
        case (reg_addr_e'(bus.addr))
            ADDR_PATTERN:   rd_val = pattern;
            ADDR_MODE:      rd_val = {6'b0, mode};
            ADDR_BRIGHT:    rd_val = bright;
            ADDR_BLINK_DIV: rd_val = blink_div;
            default:        rd_val = '0;
        endcase
    end

    // BRIGHT = 0xFF must be fully on, which the plain compare cannot reach.
    assign pwm_on     = ~mode[MODE_PWM_EN] | (pwm_cnt < bright) | (bright == 8'hFF);
    assign blink_gate = phase | ~mode[MODE_BLINK_EN];

    // Bus handshake and register file. ready drops for the cycle after every
    // accept, so it can simply be the inverse of the previous accept.
    always_ff @(posedge Mv2_CLK or posedge Mv2_RST) begin
        if (Mv2_RST) begin
            pattern   <= RST_PATTERN;
            mode      <= RST_MODE;
            bright    <= RST_BRIGHT;
            blink_div <= RST_BLINK_DIV;
            ready     <= 1'b1;
            rvalid    <= 1'b0;
            rdata     <= '0;
        end else begin
            ready  <= ~accept;
            rvalid <= accept & ~bus.we;
            if (accept && !bus.we) begin
                rdata <= rd_val;
            end
            if (accept && bus.we) begin
                case (reg_addr_e'(bus.addr))
                    ADDR_PATTERN:   pattern   <= bus.wdata;
                    ADDR_MODE:      mode      <= bus.wdata[1:0];
                    ADDR_BRIGHT:    bright    <= bus.wdata;
                    ADDR_BLINK_DIV: blink_div <= bus.wdata;
                    default:        ;
                endcase
            end
        end
    end

    always_ff @(posedge Mv2_CLK or posedge Mv2_RST) begin
        if (Mv2_RST) begin
            pwm_cnt <= '0;
            Mv2_LED <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            Mv2_LED <= pattern & {8{pwm_on}} & {8{blink_gate}};
        end
    end

    led_blink_timer #(
        .PRESCALE_W(PRESCALE_W)
    ) u_blink (
        .clk     (Mv2_CLK),
        .rst     (Mv2_RST),
        .div     (blink_div),
        .restart (restart),
        .phase   (phase)
    );

endmodule

// File: tb/tb_led_ctrl.sv
// Scoreboard bench for led_ctrl. A reference model advances on every clock
// edge from the register rules (cycle counts since reset, tick counts since
// the last blink restart) and queues the expected LED value and read data;
// a monitor on the falling edge pops and compares against the DUT.
module tb_led_ctrl;
    import led_regs_pkg::*;

    localparam int unsigned PW  = 4;
    localparam int          PER = 1 << PW;

    logic       Mv2_CLK = 1'b0;
    logic       Mv2_RST = 1'b1;
    logic [7:0] Mv2_LED;

    led_ctrl_if bus ();

    led_ctrl #(.PRESCALE_W(PW)) dut (
        .Mv2_CLK (Mv2_CLK),
        .Mv2_RST (Mv2_RST),
        .bus     (bus),
        .Mv2_LED (Mv2_LED)
    );

    always #5 Mv2_CLK = ~Mv2_CLK;

    int chks = 0;
    int errs = 0;

    task automatic chk(input string name, input int act, input int exp);
        chks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] m_pattern, m_mode, m_bright, m_div;
    int         e;        // clock edges since reset release
    int         r;        // edge of the last blink restart (0 = reset)
    bit         m_ready, m_rvalid;
    logic [7:0] exp_led;
    logic [7:0] led_q[$];
    logic [7:0] rd_q[$];

    // Phase after edge ei: ticks fall on edges that are multiples of PER;
    // the phase flips once per (div+1) ticks counted since the restart.
    function automatic bit phase_after(input int ei);
        int n;
        n = ei / PER - r / PER;
        return ((n / (int'(m_div) + 1)) % 2) == 0;
    endfunction

    always begin
        @(posedge Mv2_CLK or posedge Mv2_RST);
        if (Mv2_RST) begin
            m_pattern = 8'h00; m_mode = 8'h00; m_bright = 8'hFF; m_div = 8'h00;
            e = 0; r = 0; m_ready = 1'b1; m_rvalid = 1'b0; exp_led = 8'h00;
            led_q.delete();
            rd_q.delete();
        end else begin
            bit acc, pwm_on, gate;
            pwm_on = !m_mode[1] || (m_bright == 8'hFF) || ((e % 256) < int'(m_bright));
            gate   = !m_mode[0] || phase_after(e);
            led_q.push_back((pwm_on && gate) ? m_pattern : 8'h00);
            e   = e + 1;
            acc = bus.valid && m_ready;
            if (acc && bus.we) begin
                case (bus.addr)
                    ADDR_PATTERN:   m_pattern = bus.wdata;
                    ADDR_MODE:      m_mode    = bus.wdata & 8'h03;
                    ADDR_BRIGHT:    m_bright  = bus.wdata;
                    default: begin  m_div     = bus.wdata; r = e; end
                endcase
            end else if (acc) begin
                case (bus.addr)
                    ADDR_PATTERN:   rd_q.push_back(m_pattern);
                    ADDR_MODE:      rd_q.push_back(m_mode);
                    ADDR_BRIGHT:    rd_q.push_back(m_bright);
                    default:        rd_q.push_back(m_div);
                endcase
            end
            m_ready  = !acc;
            m_rvalid = acc && !bus.we;
        end
    end

    // Monitor
    always begin
        @(negedge Mv2_CLK);
        if (Mv2_RST) begin
            chk("rst_led", Mv2_LED, 0);
            chk("rst_ready", bus.ready, 1);
            chk("rst_rvalid", bus.rvalid, 0);
        end else begin
            if (led_q.size() > 0) exp_led = led_q.pop_front();
            chk("led", Mv2_LED, exp_led);
            chk("ready", bus.ready, m_ready);
            chk("rvalid", bus.rvalid, m_rvalid);
            if (bus.rvalid) begin
                if (rd_q.size() == 0) begin
                    chks++;
                    errs++;
                    $display("FAIL rdata_unexpected: got 0x%0h with no read pending", bus.rdata);
                end else begin
                    chk("rdata", bus.rdata, rd_q.pop_front());
                end
            end
        end
    end

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting edge, with valid released.
    task automatic txn(input bit we, input logic [1:0] addr, input logic [7:0] wdata,
                       output int stalls);
        stalls = 0;
        bus.valid = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
        while (!m_ready && stalls < 4) begin
            @(negedge Mv2_CLK);
            stalls++;
        end
        if (!m_ready) begin
            chks++;
            errs++;
            $display("FAIL txn_timeout: got no accept within %0d cycles expected accept", stalls);
        end else begin
            @(posedge Mv2_CLK);
        end
        @(negedge Mv2_CLK);
        bus.valid = 1'b0;
    endtask

    initial begin
        int st, cnt;
        int bvals[3];
        int bexp[3];
        bvals = '{8'h40, 8'h00, 8'hFF};
        bexp  = '{64, 0, 256};
        bus.valid = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

        repeat (3) @(negedge Mv2_CLK);
        #2 Mv2_RST = 1'b0;
        @(negedge Mv2_CLK);

        // Reset value of BRIGHT through the read path
        txn(1'b0, ADDR_BRIGHT, 8'h00, st);

        // Plain pattern write, one-cycle latency, ready low for one cycle
        txn(1'b1, ADDR_MODE, 8'h00, st);
        txn(1'b1, ADDR_PATTERN, 8'hA5, st);
        chk("ready_low_after_accept", bus.ready, 0);
        @(negedge Mv2_CLK);
        chk("ready_back_high", bus.ready, 1);
        chk("led_a5", Mv2_LED, 8'hA5);

        // MODE readback masks bits [7:2]; back-to-back request stalls once
        txn(1'b1, ADDR_MODE, 8'hFF, st);
        txn(1'b0, ADDR_MODE, 8'h00, st);
        chk("b2b_stall", st, 1);
        chk("rd_mode", bus.rdata, 8'h03);
        @(negedge Mv2_CLK);
        chk("rvalid_single", bus.rvalid, 0);

        // PWM duty over one full counter period
        txn(1'b1, ADDR_PATTERN, 8'hFF, st);
        txn(1'b1, ADDR_MODE, 8'h02, st);
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, ADDR_BRIGHT, bvals[i][7:0], st);
            cnt = 0;
            repeat (256) begin
                @(negedge Mv2_CLK);
                if (Mv2_LED == 8'hFF) cnt++;
            end
            chk($sformatf("pwm_lit_bright_%0h", bvals[i]), cnt, bexp[i]);
        end

        // Blink with BLINK_DIV written exactly on a tick edge
        txn(1'b1, ADDR_PATTERN, 8'h0F, st);
        txn(1'b1, ADDR_MODE, 8'h01, st);
        while (!(((e + 1) % PER) == 0 && m_ready)) @(negedge Mv2_CLK);
        txn(1'b1, ADDR_BLINK_DIV, 8'd2, st);
        cnt = 0;
        repeat (48) begin
            @(negedge Mv2_CLK);
            if (Mv2_LED == 8'h0F) cnt++;
        end
        chk("blink_on_half", cnt, 48);
        cnt = 0;
        repeat (48) begin
            @(negedge Mv2_CLK);
            if (Mv2_LED == 8'h00) cnt++;
        end
        chk("blink_off_half", cnt, 48);
        @(negedge Mv2_CLK);
        chk("blink_relit", Mv2_LED, 8'h0F);

        // Randomized traffic
        repeat (150) begin
            repeat ($urandom_range(0, 3)) @(negedge Mv2_CLK);
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom), st);
        end

        // Reset in the middle of an accepted read
        txn(1'b1, ADDR_MODE, 8'h00, st);
        txn(1'b1, ADDR_PATTERN, 8'hFF, st);
        @(negedge Mv2_CLK);
        bus.valid = 1'b1; bus.we = 1'b0; bus.addr = ADDR_PATTERN;
        while (!m_ready) @(negedge Mv2_CLK);
        chk("led_before_reset", Mv2_LED, 8'hFF);
        @(posedge Mv2_CLK);
        #2 Mv2_RST = 1'b1;
        bus.valid = 1'b0;
        #1;
        chk("async_rst_led", Mv2_LED, 0);
        chk("async_rst_ready", bus.ready, 1);
        chk("async_rst_rvalid", bus.rvalid, 0);
        @(negedge Mv2_CLK);
        #2 Mv2_RST = 1'b0;
        @(negedge Mv2_CLK);
        txn(1'b0, ADDR_PATTERN, 8'h00, st);
        chk("pattern_after_reset", bus.rdata, 8'h00);
        txn(1'b0, ADDR_BRIGHT, 8'h00, st);
        chk("bright_after_reset", bus.rdata, 8'hFF);

        repeat (3) @(negedge Mv2_CLK);
        chk("reads_outstanding", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chks, errs);
        $finish;
    end

endmodule
